mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single data-memory port between the instruction-fetch unit (IF) and the load/store unit (LS). It sequences one outstanding memory transaction at a time, issues the grant, and routes the memory response back to the requester that owns the transaction. LS requests are prioritised, with a starvation guard so that fetch always makes progress. It sits between the pipeline front/back ends and the memory bus, downstream of the data-memory control signals (`mem_d_we`, `mem_d_wdsrc`).

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width; byte-enable width is `DW/8`.
- `MAX_WAIT`, default 4: consecutive lost arbitrations tolerated by IF before it is forced to win; legal range is 1 or greater.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `if_req`  in  1  fetch request; must be held with a stable address until `if_gnt`.
- `if_addr`  in  AW  fetch address.
- `if_gnt`  out  1  fetch request accepted this cycle.
- `if_rvalid`  out  1  fetch response valid (single-cycle pulse).
- `if_rdata`  out  DW  fetch data; 0 when `if_rvalid` is 0.
- `ls_req`, `ls_we`, `ls_be[DW/8]`, `ls_addr[AW]`, `ls_wdata[DW]`  in  load/store request; all must be stable until `ls_gnt`.
- `ls_gnt`, `ls_rvalid`  out  1  same meaning as the IF signals.
- `ls_rdata`  out  DW  load data; 0 when `ls_rvalid` is 0.
- `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`  out  request to memory.
- `mem_ready`  in  1  memory accepts the request this cycle.
- `mem_rvalid`  in  1  memory response; it is also returned for writes.
- `mem_rdata`  in  DW  memory read data.
- `busy`  out  1  a transaction is outstanding.

## Operation
- The FSM has two states, IDLE and WAIT_RESP; `owner` is a 1-bit register holding IF or LS.
- **IDLE:** arbitration is combinational.
  - The winner's fields drive `mem_*` and `mem_req` is asserted.
  - If `mem_ready` is 1, the winner's `gnt` is asserted, `owner` is set to the winner, and the FSM moves to WAIT_RESP.
  - If `mem_ready` is 0, no grant is issued and arbitration is re-evaluated next cycle.
- **Priority:** LS beats IF, except when `starve_cnt == MAX_WAIT`, in which case IF wins.
- **Starvation counter `starve_cnt`:**
  - Width is `$clog2(MAX_WAIT+1)`; the counter saturates.
  - It increments on a cycle where `if_req` is high and `ls_gnt` fires.
  - It clears when `if_gnt` fires or when `if_req` is low.
- **WAIT_RESP:**
  - `mem_req` is 0 and no grants are issued.
  - On `mem_rvalid`, the owner's `rvalid` is pulsed and `mem_rdata` is forwarded to the owner's `rdata`; the FSM returns to IDLE.
- `mem_rvalid` while in IDLE is a stray response; it is dropped and no `rvalid` is produced.
- A write completes when `ls_rvalid` is pulsed; `ls_rdata` carries `mem_rdata` unchanged and is don't-care for writes.
- `busy` equals (state == WAIT_RESP).

## Timing
- **Reset values:** state IDLE, `owner` IF, `starve_cnt` 0. All `gnt`, `rvalid` and `mem_req` outputs are 0, and all `rdata` outputs are 0.
  - `mem_req` is forced to 0 while `rst` is high.
- **Grant latency:** 0 cycles. `gnt` is asserted in the same cycle as the `mem_req && mem_ready` handshake.
- **Response latency added:** 0 cycles. `rvalid` is asserted in the same cycle as `mem_rvalid`.
- **Back-to-back:** after a response in cycle M, the next grant is possible at M+1 at the earliest. Peak throughput is one transaction per 2 cycles when memory latency is 1.
- **Simultaneous requests in IDLE:** exactly one grant is issued; the loser keeps its request asserted.
- **Reset mid-transaction:** the outstanding transaction is abandoned, with no `rvalid` issued. A late `mem_rvalid` arriving after reset lands in IDLE and is dropped.
- A requester dropping `req` before `gnt` is a protocol violation; the arbiter state is still not corrupted.

## Configuration
- `ARB_ROUND_ROBIN_EN`:
  - **Defined:** on simultaneous requests, the winner alternates. The requester that was not the last to be granted wins. `starve_cnt` and `MAX_WAIT` are unused and the counter is not built.
  - **Undefined:** fixed LS priority with the starvation guard described under Operation.

## Test plan
- **Single fetch:** `if_req` with `if_addr=0x100`, `mem_ready=1`, response 2 cycles later with `mem_rdata=0xDEADBEEF` → `if_gnt` in cycle 0, `busy` for 2 cycles, `if_rvalid=1` with `if_rdata=0xDEADBEEF` for exactly 1 cycle, `ls_rvalid` stays 0.
- **Simultaneous requests:** `if_req` and `ls_req` together (store, `ls_be=4'b0011`, `ls_wdata=0x1234`) → `ls_gnt` first with `mem_we=1` and `mem_be=0011`; after `ls_rvalid`, `if_gnt` at the next cycle.
- **Starvation, `MAX_WAIT=4`:** `ls_req` held continuously and `if_req` held → 4 LS grants, then the 5th grant goes to IF. With `ARB_ROUND_ROBIN_EN` defined, grants alternate LS, IF, LS, IF.
- **Backpressure:** `mem_ready=0` for 3 cycles with `ls_req` held → no `gnt`, `mem_req=1` throughout; grant in the cycle `mem_ready` rises.
- **Reset mid-transaction:** assert `rst` during WAIT_RESP, deassert it, then pulse `mem_rvalid` → no `rvalid` on either side, `busy=0`, and the next request is granted normally.
- **Stray response:** `mem_rvalid=1` in IDLE with no grant pending → both `rvalid` outputs 0 and both `rdata` outputs 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the IF/LS requesters, the shared memory port and the arbiter.
// The arbiter uses the slave modport; the requester/memory side uses master.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic [DW-1:0]   if_rdata;

  logic            ls_req;
  logic            ls_we;
  logic [DW/8-1:0] ls_be;
  logic [AW-1:0]   ls_addr;
  logic [DW-1:0]   ls_wdata;
  logic            ls_gnt;
  logic            ls_rvalid;
  logic [DW-1:0]   ls_rdata;

  logic            mem_req;
  logic            mem_we;
  logic [DW/8-1:0] mem_be;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_ready;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;

  logic            busy;

  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output if_req, if_addr,
    output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter for the shared data-memory port (IF vs LS).
// Build option ARB_ROUND_ROBIN_EN: alternate winners instead of LS priority + starvation guard.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, WAIT_RESP} state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  state_t state_reg, state_next;
  logic   owner_reg, owner_next;
  logic   if_win;
  logic   if_gnt_c, ls_gnt_c;

`ifdef ARB_ROUND_ROBIN_EN
  // owner_reg still holds the last granted requester after the response, so it doubles as RR pointer.
  assign if_win = bus.if_req && (!bus.ls_req || owner_reg == OWN_LS);
`else
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] starve_cnt_reg, starve_cnt_next;

  assign if_win = bus.if_req && (!bus.ls_req || starve_cnt_reg == CW'(MAX_WAIT));

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!bus.if_req || if_gnt_c) begin
      starve_cnt_next = '0;
    end else if (ls_gnt_c && starve_cnt_reg != CW'(MAX_WAIT)) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      owner_reg <= OWN_IF;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    if_gnt_c      = 1'b0;
    ls_gnt_c      = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.if_rdata  = '0;
    bus.ls_rvalid = 1'b0;
    bus.ls_rdata  = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    case (state_reg)
      IDLE: begin
        if (bus.if_req || bus.ls_req) begin
          bus.mem_req = 1'b1;
          if (if_win) begin
            bus.mem_be   = '1;
            bus.mem_addr = bus.if_addr;
          end else begin
            bus.mem_we    = bus.ls_we;
            bus.mem_be    = bus.ls_be;
            bus.mem_addr  = bus.ls_addr;
            bus.mem_wdata = bus.ls_wdata;
          end
          if (bus.mem_ready) begin
            if_gnt_c   = if_win;
            ls_gnt_c   = !if_win;
            owner_next = if_win ? OWN_IF : OWN_LS;
            state_next = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        if (bus.mem_rvalid) begin
          if (owner_reg == OWN_IF) begin
            bus.if_rvalid = 1'b1;
            bus.if_rdata  = bus.mem_rdata;
          end else begin
            bus.ls_rvalid = 1'b1;
            bus.ls_rdata  = bus.mem_rdata;
          end
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Registers are held by the async reset; the combinational outputs must be quiet too.
    if (rst) begin
      if_gnt_c      = 1'b0;
      ls_gnt_c      = 1'b0;
      bus.if_rvalid = 1'b0;
      bus.if_rdata  = '0;
      bus.ls_rvalid = 1'b0;
      bus.ls_rdata  = '0;
      bus.mem_req   = 1'b0;
    end
  end

  assign bus.if_gnt = if_gnt_c;
  assign bus.ls_gnt = ls_gnt_c;
  assign bus.busy   = (state_reg == WAIT_RESP);

endmodule
